// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared types and constants for the system-pipe retire stage.
//   - bp_lanes_max_gp      : maximum number of retire lanes
//   - bp_pc_max_w_gp       : storage width of the PC field in a stage entry
//   - bp_opcode_system_gp  : RISC-V SYSTEM major opcode
//   - bp_csr_funct3_e      : CSR instruction funct3 encodings
//   - bp_be_sys_stage_s    : one shift-register stage payload (valid kept separately)
//   - bp_popcount4         : population count over the maximum lane vector
package bp_be_pkg;

    localparam int unsigned bp_lanes_max_gp     = 4;
    localparam int unsigned bp_pc_max_w_gp      = 64;
    localparam logic [6:0]  bp_opcode_system_gp = 7'b1110011;

    typedef enum logic [2:0] {
        CsrRw  = 3'b001,
        CsrRs  = 3'b010,
        CsrRc  = 3'b011,
        CsrRwi = 3'b101,
        CsrRsi = 3'b110,
        CsrRci = 3'b111
    } bp_csr_funct3_e;

    // Valid bits live outside the struct so only they carry the async reset.
    typedef struct packed {
        logic [bp_pc_max_w_gp-1:0] pc;
        logic [63:0]               vaddr;
        logic [63:0]               rs2;
        logic [31:0]               instr;
        logic                      iscore;
        logic                      fscore;
        logic                      spec_w;
    } bp_be_sys_stage_s;

    function automatic logic [2:0] bp_popcount4(input logic [bp_lanes_max_gp-1:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/bp_be_sys_retire_lane.sv
// bp_be_sys_retire_lane: one retire lane. Holds a depth_p-stage shift register of issued
// system ops and computes CSR read-modify-write data for the op in the last stage.
// Ports:
//   clk_i, reset_n_i, flush_i        : clock, async active-low reset, valid-kill
//   issue_*_i                        : fields captured into stage 0 every cycle
//   retire_queue_v_i, retire_data_i  : CSR RMW qualifier and old CSR / writeback data
//   tail_v_o, any_v_o                : last-stage valid, OR of all stage valids
//   npc_o, vaddr_o, instr_o          : last-stage next PC, rs1+imm, instruction
//   data_o                           : CSR RMW result (or retire_data_i passthrough)
//   iscore_o, fscore_o, spec_w_o     : last-stage scoreboard flags
module bp_be_sys_retire_lane
    import bp_be_pkg::*;
#(
    parameter int unsigned depth_p       = 2,
    parameter int unsigned vaddr_width_p = 39
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     flush_i,
    input  logic                     issue_v_i,
    input  logic [vaddr_width_p-1:0] issue_pc_i,
    input  logic [63:0]              issue_rs1_i,
    input  logic [63:0]              issue_imm_i,
    input  logic [63:0]              issue_rs2_i,
    input  logic [31:0]              issue_instr_i,
    input  logic                     issue_iscore_i,
    input  logic                     issue_fscore_i,
    input  logic                     issue_spec_w_i,
    input  logic                     retire_queue_v_i,
    input  logic [63:0]              retire_data_i,
    output logic                     tail_v_o,
    output logic                     any_v_o,
    output logic [vaddr_width_p-1:0] npc_o,
    output logic [63:0]              vaddr_o,
    output logic [63:0]              data_o,
    output logic [31:0]              instr_o,
    output logic                     iscore_o,
    output logic                     fscore_o,
    output logic                     spec_w_o
);

    logic [depth_p-1:0] r_v;
    logic [depth_p-1:0] w_v_d;
    bp_be_sys_stage_s   r_stage [depth_p];
    bp_be_sys_stage_s   w_issue;
    bp_be_sys_stage_s   w_tail;
    logic [63:0]        w_npc;
    logic [63:0]        w_zimm;
    logic               w_unused_lane;

    always_comb begin
        w_issue                        = '0;
        w_issue.pc[vaddr_width_p-1:0]  = issue_pc_i;
        w_issue.vaddr                  = issue_rs1_i + issue_imm_i;
        w_issue.rs2                    = issue_rs2_i;
        w_issue.instr                  = issue_instr_i;
        w_issue.iscore                 = issue_iscore_i;
        w_issue.fscore                 = issue_fscore_i;
        w_issue.spec_w                 = issue_spec_w_i;
    end

    // Flush wins over the same-cycle capture.
    always_comb begin
        w_v_d = '0;
        if (!flush_i) begin
            w_v_d[0] = issue_v_i;
            for (int i = 1; i < int'(depth_p); i++) begin
                w_v_d[i] = r_v[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_v <= '0;
        end else begin
            r_v <= w_v_d;
        end
    end

    // Payload is not reset and is not cleared by flush; only valids matter.
    always_ff @(posedge clk_i) begin
        r_stage[0] <= w_issue;
        for (int i = 1; i < int'(depth_p); i++) begin
            r_stage[i] <= r_stage[i-1];
        end
    end

    assign w_tail   = r_stage[depth_p-1];
    assign tail_v_o = r_v[depth_p-1];
    assign any_v_o  = |r_v;
    assign w_npc    = w_tail.pc + 64'd4;
    assign npc_o    = w_npc[vaddr_width_p-1:0];
    assign vaddr_o  = w_tail.vaddr;
    assign instr_o  = w_tail.instr;
    assign iscore_o = w_tail.iscore;
    assign fscore_o = w_tail.fscore;
    assign spec_w_o = w_tail.spec_w;

    // rs2 is staged for downstream consumers but not needed by this lane's outputs.
    assign w_unused_lane = ^{w_npc, w_tail.rs2};

    always_comb begin
        w_zimm = {59'd0, w_tail.instr[19:15]};
        data_o = retire_data_i;
        if (retire_queue_v_i && (w_tail.instr[6:0] == bp_opcode_system_gp)) begin
            case (w_tail.instr[14:12])
                CsrRsi:  data_o = w_zimm | retire_data_i;
                CsrRci:  data_o = ~w_zimm & retire_data_i;
                CsrRwi:  data_o = w_zimm;
                CsrRs:   data_o = w_tail.vaddr | retire_data_i;
                CsrRc:   data_o = ~w_tail.vaddr & retire_data_i;
                CsrRw:   data_o = w_tail.vaddr;
                default: data_o = retire_data_i;
            endcase
        end
    end

endmodule

// File: rtl/bp_be_sys_retire_stage.sv
// bp_be_sys_retire_stage: multi-lane retire staging pipe for the system pipe.
// Each lane delays issued ops by depth_p cycles; retire outputs are combinational from the
// last stage and the retire qualifiers. Lane 0 is oldest: an excepting retire in lane j
// squashes instret in every younger lane.
// Optional feature: define BP_BE_SYS_INSTRET_CNT_EN to build a 64-bit retired-instruction
// counter; otherwise instret_cnt_o is tied to zero.
// Ports:
//   clk_i, reset_n_i, flush_i            : clock, async active-low reset, kill staged ops
//   issue_*_i                            : per-lane issue fields (packed, lane 0 in LSBs)
//   retire_{v,queue_v,exc,special}_i     : per-lane retire qualifiers
//   retire_data_i                        : per-lane old CSR / writeback data
//   retire_{v,instret,iscore,fscore}_o   : per-lane retire strobes
//   retire_{npc,vaddr,data,instr}_o      : per-lane retire payload
//   instret_cnt_o, pending_o             : retired count, any staged op valid
module bp_be_sys_retire_stage
    import bp_be_pkg::*;
#(
    parameter int unsigned lanes_p       = 1,
    parameter int unsigned depth_p       = 2,
    parameter int unsigned vaddr_width_p = 39
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             flush_i,
    input  logic [lanes_p-1:0]               issue_v_i,
    input  logic [lanes_p*vaddr_width_p-1:0] issue_pc_i,
    input  logic [lanes_p*64-1:0]            issue_rs1_i,
    input  logic [lanes_p*64-1:0]            issue_imm_i,
    input  logic [lanes_p*64-1:0]            issue_rs2_i,
    input  logic [lanes_p*32-1:0]            issue_instr_i,
    input  logic [lanes_p-1:0]               issue_iscore_i,
    input  logic [lanes_p-1:0]               issue_fscore_i,
    input  logic [lanes_p-1:0]               issue_spec_w_i,
    input  logic [lanes_p-1:0]               retire_v_i,
    input  logic [lanes_p-1:0]               retire_queue_v_i,
    input  logic [lanes_p-1:0]               retire_exc_i,
    input  logic [lanes_p-1:0]               retire_special_i,
    input  logic [lanes_p*64-1:0]            retire_data_i,
    output logic [lanes_p-1:0]               retire_v_o,
    output logic [lanes_p-1:0]               retire_instret_o,
    output logic [lanes_p-1:0]               retire_iscore_o,
    output logic [lanes_p-1:0]               retire_fscore_o,
    output logic [lanes_p*vaddr_width_p-1:0] retire_npc_o,
    output logic [lanes_p*64-1:0]            retire_vaddr_o,
    output logic [lanes_p*64-1:0]            retire_data_o,
    output logic [lanes_p*32-1:0]            retire_instr_o,
    output logic [63:0]                      instret_cnt_o,
    output logic                             pending_o
);

    logic [lanes_p-1:0] w_tail_v;
    logic [lanes_p-1:0] w_any_v;
    logic [lanes_p-1:0] w_iscore;
    logic [lanes_p-1:0] w_fscore;
    logic [lanes_p-1:0] w_spec_w;
    logic               w_older_exc;

    for (genvar k = 0; k < lanes_p; k++) begin : g_lane
        bp_be_sys_retire_lane #(
            .depth_p       (depth_p),
            .vaddr_width_p (vaddr_width_p)
        ) u_lane (
            .clk_i            (clk_i),
            .reset_n_i        (reset_n_i),
            .flush_i          (flush_i),
            .issue_v_i        (issue_v_i[k]),
            .issue_pc_i       (issue_pc_i[k*vaddr_width_p +: vaddr_width_p]),
            .issue_rs1_i      (issue_rs1_i[k*64 +: 64]),
            .issue_imm_i      (issue_imm_i[k*64 +: 64]),
            .issue_rs2_i      (issue_rs2_i[k*64 +: 64]),
            .issue_instr_i    (issue_instr_i[k*32 +: 32]),
            .issue_iscore_i   (issue_iscore_i[k]),
            .issue_fscore_i   (issue_fscore_i[k]),
            .issue_spec_w_i   (issue_spec_w_i[k]),
            .retire_queue_v_i (retire_queue_v_i[k]),
            .retire_data_i    (retire_data_i[k*64 +: 64]),
            .tail_v_o         (w_tail_v[k]),
            .any_v_o          (w_any_v[k]),
            .npc_o            (retire_npc_o[k*vaddr_width_p +: vaddr_width_p]),
            .vaddr_o          (retire_vaddr_o[k*64 +: 64]),
            .data_o           (retire_data_o[k*64 +: 64]),
            .instr_o          (retire_instr_o[k*32 +: 32]),
            .iscore_o         (w_iscore[k]),
            .fscore_o         (w_fscore[k]),
            .spec_w_o         (w_spec_w[k])
        );
    end

    assign pending_o = |w_any_v;

    // Walk lanes oldest-first so an exception in an older lane blocks all younger instret.
    always_comb begin
        retire_v_o       = retire_v_i & w_tail_v;
        retire_instret_o = '0;
        retire_iscore_o  = '0;
        retire_fscore_o  = '0;
        w_older_exc      = 1'b0;
        for (int k = 0; k < int'(lanes_p); k++) begin
            retire_instret_o[k] = retire_v_o[k] & retire_queue_v_i[k] & ~retire_exc_i[k]
                                & ~w_older_exc;
            retire_iscore_o[k]  = retire_instret_o[k] & w_iscore[k]
                                & (~w_spec_w[k] | retire_special_i[k]);
            retire_fscore_o[k]  = retire_instret_o[k] & w_fscore[k]
                                & (~w_spec_w[k] | retire_special_i[k]);
            w_older_exc         = w_older_exc | (retire_v_o[k] & retire_exc_i[k]);
        end
    end

`ifdef BP_BE_SYS_INSTRET_CNT_EN
    logic [63:0]                r_instret_cnt;
    logic [bp_lanes_max_gp-1:0] w_instret_pad;

    always_comb begin
        w_instret_pad                = '0;
        w_instret_pad[lanes_p-1:0]   = retire_instret_o;
    end

    // Counts architectural retirement only, so flush does not touch it.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_instret_cnt <= '0;
        end else begin
            r_instret_cnt <= r_instret_cnt + 64'(bp_popcount4(w_instret_pad));
        end
    end

    assign instret_cnt_o = r_instret_cnt;
`else
    assign instret_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_be_sys_retire_stage.sv
// Directed bench for bp_be_sys_retire_stage with two lanes and a two-stage pipe.
module tb_bp_be_sys_retire_stage;

    localparam int unsigned L = 2;
    localparam int unsigned D = 2;
    localparam int unsigned V = 39;

`ifdef BP_BE_SYS_INSTRET_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    localparam logic [2:0] F3Rw  = 3'b001;
    localparam logic [2:0] F3Rs  = 3'b010;
    localparam logic [2:0] F3Rc  = 3'b011;
    localparam logic [2:0] F3Rwi = 3'b101;
    localparam logic [2:0] F3Rsi = 3'b110;
    localparam logic [2:0] F3Rci = 3'b111;

    logic             clk_i = 1'b0;
    logic             reset_n_i;
    logic             flush_i;
    logic [L-1:0]     issue_v_i;
    logic [L*V-1:0]   issue_pc_i;
    logic [L*64-1:0]  issue_rs1_i;
    logic [L*64-1:0]  issue_imm_i;
    logic [L*64-1:0]  issue_rs2_i;
    logic [L*32-1:0]  issue_instr_i;
    logic [L-1:0]     issue_iscore_i;
    logic [L-1:0]     issue_fscore_i;
    logic [L-1:0]     issue_spec_w_i;
    logic [L-1:0]     retire_v_i;
    logic [L-1:0]     retire_queue_v_i;
    logic [L-1:0]     retire_exc_i;
    logic [L-1:0]     retire_special_i;
    logic [L*64-1:0]  retire_data_i;
    logic [L-1:0]     retire_v_o;
    logic [L-1:0]     retire_instret_o;
    logic [L-1:0]     retire_iscore_o;
    logic [L-1:0]     retire_fscore_o;
    logic [L*V-1:0]   retire_npc_o;
    logic [L*64-1:0]  retire_vaddr_o;
    logic [L*64-1:0]  retire_data_o;
    logic [L*32-1:0]  retire_instr_o;
    logic [63:0]      instret_cnt_o;
    logic             pending_o;

    int n_checks;
    int n_pass;

    always #5 clk_i = ~clk_i;

    bp_be_sys_retire_stage #(
        .lanes_p       (L),
        .depth_p       (D),
        .vaddr_width_p (V)
    ) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .flush_i          (flush_i),
        .issue_v_i        (issue_v_i),
        .issue_pc_i       (issue_pc_i),
        .issue_rs1_i      (issue_rs1_i),
        .issue_imm_i      (issue_imm_i),
        .issue_rs2_i      (issue_rs2_i),
        .issue_instr_i    (issue_instr_i),
        .issue_iscore_i   (issue_iscore_i),
        .issue_fscore_i   (issue_fscore_i),
        .issue_spec_w_i   (issue_spec_w_i),
        .retire_v_i       (retire_v_i),
        .retire_queue_v_i (retire_queue_v_i),
        .retire_exc_i     (retire_exc_i),
        .retire_special_i (retire_special_i),
        .retire_data_i    (retire_data_i),
        .retire_v_o       (retire_v_o),
        .retire_instret_o (retire_instret_o),
        .retire_iscore_o  (retire_iscore_o),
        .retire_fscore_o  (retire_fscore_o),
        .retire_npc_o     (retire_npc_o),
        .retire_vaddr_o   (retire_vaddr_o),
        .retire_data_o    (retire_data_o),
        .retire_instr_o   (retire_instr_o),
        .instret_cnt_o    (instret_cnt_o),
        .pending_o        (pending_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_csr(input logic [2:0] f3, input logic [4:0] rs1f);
        return {12'h300, rs1f, f3, 5'd1, 7'b1110011};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_retire();
        retire_v_i       = '0;
        retire_queue_v_i = '0;
        retire_exc_i     = '0;
        retire_special_i = '0;
        retire_data_i    = '0;
    endtask

    task automatic set_lane(input int l, input logic [V-1:0] pc, input logic [63:0] rs1,
                            input logic [63:0] imm, input logic [31:0] instr,
                            input logic ic, input logic fc, input logic sw);
        issue_v_i[l]          = 1'b1;
        issue_pc_i[l*V +: V]  = pc;
        issue_rs1_i[l*64 +: 64]  = rs1;
        issue_imm_i[l*64 +: 64]  = imm;
        issue_rs2_i[l*64 +: 64]  = rs1 ^ imm;
        issue_instr_i[l*32 +: 32] = instr;
        issue_iscore_i[l]     = ic;
        issue_fscore_i[l]     = fc;
        issue_spec_w_i[l]     = sw;
    endtask

    // Capture on the next edge, then one more edge brings the op to the last stage.
    task automatic advance();
        step();
        issue_v_i = '0;
        step();
    endtask

    task automatic retire_all(input logic [63:0] d0, input logic [63:0] d1);
        retire_v_i       = 2'b11;
        retire_queue_v_i = 2'b11;
        retire_exc_i     = 2'b00;
        retire_special_i = 2'b00;
        retire_data_i    = {d1, d0};
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset_n_i = 1'b0;
        flush_i   = 1'b0;
        issue_v_i = '0; issue_pc_i = '0; issue_rs1_i = '0; issue_imm_i = '0;
        issue_rs2_i = '0; issue_instr_i = '0; issue_iscore_i = '0; issue_fscore_i = '0;
        issue_spec_w_i = '0;
        clear_retire();

        // Reset state
        #12;
        retire_v_i = 2'b11;
        #1;
        check("rst_pending", 64'(pending_o), 64'h0);
        check("rst_retire_v", 64'(retire_v_o), 64'h0);
        check("rst_cnt", instret_cnt_o, 64'h0);
        clear_retire();
        reset_n_i = 1'b1;

        // CSRRS lane 0, CSRRCI lane 1; also confirms D-cycle latency
        set_lane(0, 39'h80000000, 64'h10, 64'h0, mk_csr(F3Rs, 5'd1), 1'b0, 1'b0, 1'b0);
        set_lane(1, 39'h80000004, 64'h1000, 64'h20, mk_csr(F3Rci, 5'd5), 1'b0, 1'b0, 1'b0);
        step();
        issue_v_i  = '0;
        retire_v_i = 2'b11;
        #1;
        check("lat_retire_v_early", 64'(retire_v_o), 64'h0);
        check("lat_pending", 64'(pending_o), 64'h1);
        retire_v_i = '0;
        step();
        retire_all(64'h01, 64'hFF);
        #1;
        check("csrrs_retire_v", 64'(retire_v_o), 64'h3);
        check("csrrs_data", retire_data_o[63:0], 64'h11);
        check("csrrci_data", retire_data_o[127:64], 64'hFA);
        check("csrrci_vaddr", retire_vaddr_o[127:64], 64'h1020);
        check("npc0", 64'(retire_npc_o[V-1:0]), 64'h80000004);
        check("instr0", 64'(retire_instr_o[31:0]), 64'(mk_csr(F3Rs, 5'd1)));
        check("instret_both", 64'(retire_instret_o), 64'h3);
        step();
        check("cnt_after_two", instret_cnt_o, CntEn ? 64'h2 : 64'h0);
        check("pending_drained", 64'(pending_o), 64'h0);
        clear_retire();

        // CSRRW / CSRRC, queue gating, in-order exception squash
        set_lane(0, 39'h100, 64'h5, 64'h3, mk_csr(F3Rw, 5'd2), 1'b0, 1'b0, 1'b0);
        set_lane(1, 39'h104, 64'h0F, 64'h0, mk_csr(F3Rc, 5'd3), 1'b0, 1'b0, 1'b0);
        advance();
        retire_all(64'hF0, 64'hFF);
        #1;
        check("csrrw_data", retire_data_o[63:0], 64'h8);
        check("csrrc_data", retire_data_o[127:64], 64'hF0);
        retire_queue_v_i = 2'b01;
        #1;
        check("noqueue_passthru", retire_data_o[127:64], 64'hFF);
        retire_queue_v_i = 2'b11;
        retire_exc_i     = 2'b10;
        #1;
        check("exc_young_instret", 64'(retire_instret_o), 64'h1);
        retire_exc_i = 2'b01;
        #1;
        check("exc_old_instret", 64'(retire_instret_o), 64'h0);
        check("exc_old_retire_v", 64'(retire_v_o), 64'h3);
        step();
        check("cnt_exc_unchanged", instret_cnt_o, CntEn ? 64'h2 : 64'h0);
        clear_retire();

        // Immediate CSR forms
        set_lane(0, 39'h200, 64'h1234, 64'h0, mk_csr(F3Rwi, 5'h1F), 1'b0, 1'b0, 1'b0);
        set_lane(1, 39'h204, 64'h0, 64'h0, mk_csr(F3Rsi, 5'h3), 1'b0, 1'b0, 1'b0);
        advance();
        retire_all(64'h0, 64'h10);
        #1;
        check("csrrwi_data", retire_data_o[63:0], 64'h1F);
        check("csrrsi_data", retire_data_o[127:64], 64'h13);
        clear_retire();

        // Non-CSR ops pass retire_data_i through
        set_lane(0, 39'h300, 64'h7, 64'h7, 32'h00B50533, 1'b0, 1'b0, 1'b0);
        set_lane(1, 39'h304, 64'h7, 64'h7, 32'h00000073, 1'b0, 1'b0, 1'b0);
        advance();
        retire_all(64'hABCD, 64'h5555);
        #1;
        check("add_passthru", retire_data_o[63:0], 64'hABCD);
        check("ecall_passthru", retire_data_o[127:64], 64'h5555);
        clear_retire();

        // Flush kills same-cycle capture
        set_lane(0, 39'h400, 64'h1, 64'h1, 32'h0, 1'b0, 1'b0, 1'b0);
        set_lane(1, 39'h404, 64'h1, 64'h1, 32'h0, 1'b0, 1'b0, 1'b0);
        flush_i = 1'b1;
        step();
        flush_i   = 1'b0;
        issue_v_i = '0;
        check("flush_pending", 64'(pending_o), 64'h0);
        step();
        retire_v_i = 2'b11;
        #1;
        check("flush_no_retire", 64'(retire_v_o), 64'h0);
        clear_retire();

        // Flush kills an op already in stage 0
        set_lane(0, 39'h500, 64'h1, 64'h1, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        issue_v_i = '0;
        flush_i   = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush_stage0_pending", 64'(pending_o), 64'h0);

        // Scoreboard release rules
        set_lane(0, 39'h600, 64'h0, 64'h0, 32'h00000013, 1'b1, 1'b1, 1'b1);
        set_lane(1, 39'h604, 64'h0, 64'h0, 32'h00000013, 1'b1, 1'b0, 1'b0);
        advance();
        retire_all(64'h0, 64'h0);
        #1;
        check("spec_iscore_blocked", 64'(retire_iscore_o), 64'h2);
        check("spec_fscore_blocked", 64'(retire_fscore_o), 64'h0);
        retire_special_i = 2'b01;
        #1;
        check("special_iscore", 64'(retire_iscore_o), 64'h3);
        check("special_fscore", 64'(retire_fscore_o), 64'h1);
        retire_exc_i = 2'b01;
        #1;
        check("exc_iscore_squash", 64'(retire_iscore_o), 64'h0);
        clear_retire();

        // Counter wrap (preset only exists when the counter is built)
        set_lane(0, 39'h700, 64'h0, 64'h0, 32'h00000013, 1'b0, 1'b0, 1'b0);
        set_lane(1, 39'h704, 64'h0, 64'h0, 32'h00000013, 1'b0, 1'b0, 1'b0);
        advance();
`ifdef BP_BE_SYS_INSTRET_CNT_EN
        dut.r_instret_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
`endif
        retire_all(64'h0, 64'h0);
        step();
        check("cnt_wrap", instret_cnt_o, CntEn ? 64'h1 : 64'h0);
        clear_retire();

        // Async reset mid-stream, then first capture after release
        set_lane(0, 39'h800, 64'h0, 64'h0, 32'h00000013, 1'b0, 1'b0, 1'b0);
        set_lane(1, 39'h804, 64'h0, 64'h0, 32'h00000013, 1'b0, 1'b0, 1'b0);
        step();
        issue_v_i = '0;
        check("mid_pending_before", 64'(pending_o), 64'h1);
        #2;
        reset_n_i  = 1'b0;
        retire_v_i = 2'b11;
        #1;
        check("mid_rst_pending", 64'(pending_o), 64'h0);
        check("mid_rst_retire_v", 64'(retire_v_o), 64'h0);
        check("mid_rst_cnt", instret_cnt_o, 64'h0);
        clear_retire();
        #2;
        reset_n_i = 1'b1;
        set_lane(0, 39'h900, 64'h0, 64'h0, 32'h00000013, 1'b0, 1'b0, 1'b0);
        step();
        issue_v_i = '0;
        check("post_rst_capture", 64'(pending_o), 64'h1);
        step();
        retire_v_i = 2'b11;
        #1;
        check("post_rst_retire_v", 64'(retire_v_o), 64'h1);
        check("post_rst_npc", 64'(retire_npc_o[V-1:0]), 64'h904);
        clear_retire();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bp_be_sys_retire_stage.md
BP_BE_SYS_RETIRE_STAGE -- requirements
Module: bp_be_sys_retire_stage

Interface
REQ-001 The block SHALL be a parametrised multi-lane retire staging pipe for the system pipe, with these parameters (name, default, meaning):
- lanes_p, 1: retire lanes L, 1..4; lane 0 is oldest.
- depth_p, 2: issue-to-retire stages D, 1..4.
- vaddr_width_p, 39: PC width V.
REQ-002 Ports SHALL be (name, direction, width, meaning), with the clock and reset first:
- clk_i, in, 1: the single clock.
- reset_n_i, in, 1: asynchronous active-low reset.
- flush_i, in, 1: kill all staged ops.
- issue_v_i, in, L: per-lane capture strobe.
- issue_pc_i, in, L*V: per-lane PC.
- issue_rs1_i, issue_imm_i, issue_rs2_i, in, L*64 each: per-lane source operands.
- issue_instr_i, in, L*32: per-lane instruction.
- issue_iscore_i, issue_fscore_i, issue_spec_w_i, in, L each: scoreboard flags.
- retire_v_i, retire_queue_v_i, retire_exc_i, retire_special_i, in, L each: per-lane retire qualifiers.
- retire_data_i, in, L*64: old CSR or writeback data.
- retire_v_o, retire_instret_o, retire_iscore_o, retire_fscore_o, out, L each: per-lane retire outputs.
- retire_npc_o, out, L*V: per-lane next PC.
- retire_vaddr_o, retire_data_o, out, L*64 each: per-lane address and data.
- retire_instr_o, out, L*32: per-lane instruction.
- instret_cnt_o, out, 64: retired-instruction count.
- pending_o, out, 1: any staged op valid.

Function
REQ-003 Each lane SHALL hold a D-stage shift register of {valid, pc, vaddr=rs1+imm (64-bit wrap), rs2, instr, iscore, fscore, spec_w}, advancing every cycle.
REQ-004 Stage 0 SHALL load the issue fields with valid=issue_v_i; retire signals SHALL align with stage D-1, so latency from issue to retire output is exactly D cycles.
REQ-005 retire_v_o[k] SHALL equal retire_v_i[k] & stage-(D-1) valid[k].
REQ-006 retire_data_o[k] SHALL be computed when retire_queue_v_i[k]=1, using zimm = instr[19:15] zero-extended:
- CSRRSI: zimm|data
- CSRRCI: ~zimm&data
- CSRRWI: zimm
- CSRRS: vaddr|data
- CSRRC: ~vaddr&data
- CSRRW: vaddr
- otherwise: retire_data_i
REQ-007 retire_instret_o[k] SHALL equal retire_v_o[k] & retire_queue_v_i[k] & ~retire_exc_i[k] & no lane j<k with retire_v_o[j]&retire_exc_i[j] (in-order exception squash).
REQ-008 retire_iscore_o[k] SHALL be instret[k] & iscore & (~spec_w | special[k]); retire_fscore_o SHALL use the same rule with fscore.
REQ-009 flush_i SHALL clear every valid bit, including the stage-0 capture in the same cycle, with flush taking priority; data fields SHALL be left unchanged.
REQ-010 pending_o SHALL be the OR of all stage valid bits, registered-free (combinational from state).
REQ-011 Retire outputs SHALL be combinational from stage D-1 and the retire inputs, with no added cycle.

Reset
REQ-012 Asserting reset_n_i low SHALL clear all valid bits and instret_cnt_o immediately, without waiting for a clock edge.
REQ-013 During reset all retire_*_o single-bit outputs and pending_o SHALL be 0.
REQ-014 Reset asserted mid-operation SHALL discard all in-flight ops; the first capture after release SHALL occur on the first rising edge with reset_n_i high.

Configuration
REQ-015 With BP_BE_SYS_INSTRET_CNT_EN defined, instret_cnt_o SHALL increment each cycle by popcount(retire_instret_o), wrapping modulo 2^64, and SHALL not be affected by flush_i.
REQ-016 Without BP_BE_SYS_INSTRET_CNT_EN, instret_cnt_o SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-017 The stage entry struct, CSR funct3 encodings and lane-count limit SHALL live in bp_be_pkg.
REQ-018 One sub-module, bp_be_sys_retire_lane (per-lane shift register plus CSR RMW data), SHALL be instantiated L times; squash and counter logic SHALL stay in the top.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- L=1, D=2: CSRRS with rs1=0x10, imm=0, retire_data_i=0x01, queue_v=1 -> cycle 2 retire_data_o=0x11, instret=1.
- CSRRCI with instr[19:15]=5, data=0xFF -> retire_data_o=0xFA.
- L=2: lane 0 with exc=1, lane 1 clean -> instret=2'b00; count unchanged.
- flush_i together with issue_v_i=1 -> pending_o=0 next cycle; no retire_v_o after D cycles.
- spec_w=1, iscore=1, special=0 -> iscore_o=0; special=1 -> iscore_o=1.
- BP_BE_SYS_INSTRET_CNT_EN, count preset to 2^64-1, two lanes instret -> instret_cnt_o=1; async reset mid-stream -> count=0, pending_o=0 before the next edge.
